// File: rtl/efuse_read_ctrl_if.sv
// eFuse read request bundle between the shadow loader
// and the eFuse mux.
interface efuse_read_ctrl_if;
  logic       read_pgmen;
  logic       read_rden;
  logic       read_aen;
  logic [7:0] read_addr;
  logic [7:0] read_rdata;
  logic       busy_read;

  modport master (
    output read_pgmen,
    output read_rden,
    output read_aen,
    output read_addr,
    output busy_read,
    input  read_rdata
  );

  modport slave (
    input  read_pgmen,
    input  read_rden,
    input  read_aen,
    input  read_addr,
    input  busy_read,
    output read_rdata
  );
endinterface

// File: rtl/efuse_read_ctrl.sv
// Sequencer that copies the eFuse macro contents into
// a shadow register array, after reset and on request.
module efuse_read_ctrl #(
  parameter int NR        = 64,
  parameter int T_SETUP   = 2,
  parameter int T_AEN     = 4,
  parameter int T_HOLD    = 2,
  parameter bit AUTO_LOAD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_start,
  input  logic              rg_efuse_reg_mode,
  efuse_read_ctrl_if.master efuse,
  output logic              load_done,
  output logic              shadow_valid,
  output logic [NR*8-1:0]   shadow_data
);

  localparam int TSA  = (T_SETUP > T_AEN) ?
                        T_SETUP : T_AEN;
  localparam int TMAX = (TSA > T_HOLD) ? TSA : T_HOLD;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] C_AEN   = CW'(T_AEN - 1);
  localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD - 1);
  localparam logic [7:0]    A_LAST  = 8'(NR - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [7:0]    addr;
  logic [7:0]    addr_nxt;
  logic          pend;
  logic          armed;
  logic          start;
  logic          cap;

  logic          rden_d;
  logic          aen_d;
  logic          busy_d;
  logic          done_d;
  logic [7:0]    raddr_d;

  assign efuse.read_pgmen = 1'b0;

  // armed holds off the auto-load for one cycle after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      addr  <= '0;
      pend  <= AUTO_LOAD;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      addr  <= addr_nxt;
      armed <= 1'b1;
      if (start)
        pend <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr;
    start     = 1'b0;
    cap       = 1'b0;
    unique case (state)
      IDLE: begin
        if ((sw_start || (pend && armed)) &&
            !rg_efuse_reg_mode) begin
          start     = 1'b1;
          state_nxt = SETUP;
          cnt_nxt   = '0;
          addr_nxt  = '0;
        end
      end
      SETUP: begin
        if (rg_efuse_reg_mode) begin
          state_nxt = IDLE;
        end else if (cnt == C_SETUP) begin
          state_nxt = STROBE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STROBE: begin
        if (rg_efuse_reg_mode) begin
          state_nxt = IDLE;
        end else if (cnt == C_AEN) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (rg_efuse_reg_mode) begin
          state_nxt = IDLE;
        end else if (cnt == C_HOLD) begin
          cap     = 1'b1;
          cnt_nxt = '0;
          if (addr == A_LAST) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SETUP;
            addr_nxt  = addr + 8'd1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // decode from the next state so every output is a flop
  always_comb begin
    rden_d  = 1'b0;
    aen_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    raddr_d = '0;
    unique case (state_nxt)
      SETUP, HOLD: begin
        rden_d  = 1'b1;
        busy_d  = 1'b1;
        raddr_d = addr_nxt;
      end
      STROBE: begin
        rden_d  = 1'b1;
        aen_d   = 1'b1;
        busy_d  = 1'b1;
        raddr_d = addr_nxt;
      end
      DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      efuse.read_rden <= 1'b0;
      efuse.read_aen  <= 1'b0;
      efuse.read_addr <= '0;
      efuse.busy_read <= 1'b0;
      load_done       <= 1'b0;
      shadow_valid    <= 1'b0;
    end else begin
      efuse.read_rden <= rden_d;
      efuse.read_aen  <= aen_d;
      efuse.read_addr <= raddr_d;
      efuse.busy_read <= busy_d;
      load_done       <= done_d;
      if (start)
        shadow_valid <= 1'b0;
      else if (done_d)
        shadow_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_data <= '0;
    end else if (cap) begin
      for (int k = 0; k < NR; k++)
        if (addr == 8'(k))
          shadow_data[k*8 +: 8] <= efuse.read_rdata;
    end
  end

endmodule
